// File: rtl/peak_bin_finder.sv
// rtl/peak_bin_finder.sv - scans a re/im spectrum buffer and reports the bin of largest magnitude
module peak_bin_finder #(
  parameter int DATA_W   = 10,
  parameter int N_BINS   = 1024,
  parameter int ADDR_W   = $clog2(2*N_BINS),
  parameter int RD_LAT   = 1,
  parameter int MAG_MODE = 0,
  parameter int MIN_BIN  = 1,
  localparam int MAG_W   = (MAG_MODE != 0) ? 2*DATA_W : DATA_W+1,
  localparam int BIN_W   = $clog2(N_BINS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [MAG_W-1:0]  threshold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic [BIN_W-1:0]  peak_bin,
  output logic [MAG_W-1:0]  peak_mag,
  output logic              peak_found
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_RE, S_WAIT_RE, S_WAIT_IM, S_MAG, S_CMP, S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [2:0]         lat_q, lat_d;
  logic [DATA_W-1:0]  re_q, re_d, im_q, im_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [MAG_W-1:0]   best_mag_q, best_mag_d;
  logic [BIN_W-1:0]   best_bin_q, best_bin_d;
  logic [MAG_W-1:0]   thr_q, thr_d;
  logic [BIN_W-1:0]   peak_bin_q, peak_bin_d;
  logic [MAG_W-1:0]   peak_mag_q, peak_mag_d;
  logic               peak_found_q, peak_found_d;

  logic [DATA_W-1:0]  abs_re, abs_im;
  logic [MAG_W-1:0]   mag_calc;

  // Two's-complement negate of the most negative sample lands exactly on 2^(DATA_W-1) unsigned.
  always_comb begin
    abs_re = re_q[DATA_W-1] ? (~re_q + DATA_W'(1)) : re_q;
    abs_im = im_q[DATA_W-1] ? (~im_q + DATA_W'(1)) : im_q;
    if (MAG_MODE != 0) begin
      mag_calc = MAG_W'(abs_re) * MAG_W'(abs_re) + MAG_W'(abs_im) * MAG_W'(abs_im);
    end else begin
      mag_calc = MAG_W'(abs_re) + MAG_W'(abs_im);
    end
  end

  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    lat_d        = lat_q;
    re_d         = re_q;
    im_d         = im_q;
    mag_d        = mag_q;
    best_mag_d   = best_mag_q;
    best_bin_d   = best_bin_q;
    thr_d        = thr_q;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    peak_found_d = peak_found_q;
    mem_addr     = '0;
    mem_rd_en    = 1'b0;

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d    = S_ADDR_RE;
            bin_d      = BIN_W'(MIN_BIN);
            best_mag_d = '0;
            best_bin_d = BIN_W'(MIN_BIN);
            thr_d      = threshold;
          end
        end
        S_ADDR_RE: begin
          mem_addr  = ADDR_W'({1'b0, bin_q});
          mem_rd_en = 1'b1;
          lat_d     = 3'd1;
          state_d   = S_WAIT_RE;
        end
        S_WAIT_RE: begin
          // Real part arrives in the same cycle the imaginary read is issued.
          if (lat_q == 3'(RD_LAT)) begin
            re_d      = mem_data;
            mem_addr  = ADDR_W'({1'b1, bin_q});
            mem_rd_en = 1'b1;
            lat_d     = 3'd1;
            state_d   = S_WAIT_IM;
          end else begin
            lat_d = lat_q + 3'd1;
          end
        end
        S_WAIT_IM: begin
          if (lat_q == 3'(RD_LAT)) begin
            im_d    = mem_data;
            state_d = S_MAG;
          end else begin
            lat_d = lat_q + 3'd1;
          end
        end
        S_MAG: begin
          mag_d   = mag_calc;
          state_d = S_CMP;
        end
        S_CMP: begin
          if (mag_q > best_mag_q) begin
            best_mag_d = mag_q;
            best_bin_d = bin_q;
          end
          if (bin_q == BIN_W'(N_BINS-1)) begin
            peak_bin_d   = best_bin_d;
            peak_mag_d   = best_mag_d;
            peak_found_d = (best_mag_d >= thr_q) && (best_mag_d != '0);
            state_d      = S_FINISH;
          end else begin
            bin_d   = bin_q + BIN_W'(1);
            state_d = S_ADDR_RE;
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bin_q        <= '0;
      lat_q        <= '0;
      re_q         <= '0;
      im_q         <= '0;
      mag_q        <= '0;
      best_mag_q   <= '0;
      best_bin_q   <= '0;
      thr_q        <= '0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      peak_found_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      lat_q        <= lat_d;
      re_q         <= re_d;
      im_q         <= im_d;
      mag_q        <= mag_d;
      best_mag_q   <= best_mag_d;
      best_bin_q   <= best_bin_d;
      thr_q        <= thr_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      peak_found_q <= peak_found_d;
    end
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign done       = (state_q == S_FINISH);
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign peak_found = peak_found_q;

endmodule

// File: tb/tb_peak_bin_finder.sv
// tb/tb_peak_bin_finder.sv - randomized self-checking bench for peak_bin_finder
module tb_peak_bin_finder;
  localparam int DW   = 10;
  localparam int NB   = 16;
  localparam int AW   = 5;
  localparam int BW   = 4;
  localparam int MINB = 1;

  logic clk;
  int   n_cmp = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int g, input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL cfg%0d %s: got %0d, expected %0d", g, tag, obs, exp);
    end
  endtask

  // cfg0: RD_LAT=1, |re|+|im|; cfg1: RD_LAT=3, re^2+im^2
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int L  = (g == 0) ? 1 : 3;
    localparam int M  = (g == 0) ? 0 : 1;
    localparam int MW = (M != 0) ? 2*DW : DW+1;

    logic          rst_n, start, abort;
    logic [MW-1:0] threshold;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [DW-1:0] mem_data;
    logic          busy, done;
    logic [BW-1:0] peak_bin;
    logic [MW-1:0] peak_mag;
    logic          peak_found;

    logic [DW-1:0] mem [0:2*NB-1];
    logic          pv  [0:L-1];
    logic [AW-1:0] pa  [0:L-1];
    logic [DW-1:0] poison;
    longint        last_b, last_m;
    bit            last_f;
    bit            fin = 1'b0;

    // Memory returns data exactly L cycles after the strobe, garbage otherwise.
    always @(posedge clk) begin
      pv[0] <= mem_rd_en;
      pa[0] <= mem_addr;
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
      poison <= DW'($urandom);
    end
    assign mem_data = pv[L-1] ? mem[pa[L-1]] : poison;

    peak_bin_finder #(
      .DATA_W(DW), .N_BINS(NB), .ADDR_W(AW), .RD_LAT(L), .MAG_MODE(M), .MIN_BIN(MINB)
    ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .threshold(threshold),
      .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
      .busy(busy), .done(done), .peak_bin(peak_bin), .peak_mag(peak_mag),
      .peak_found(peak_found)
    );

    task automatic ref_scan(input longint thr, output longint eb, output longint em, output bit ef);
      longint re, im, m;
      eb = MINB;
      em = 0;
      for (int b = MINB; b < NB; b++) begin
        re = $signed(mem[b]);
        im = $signed(mem[b+NB]);
        if (M != 0) m = re*re + im*im;
        else        m = (re < 0 ? -re : re) + (im < 0 ? -im : im);
        if (m > em) begin
          em = m;
          eb = b;
        end
      end
      ef = (em >= thr) && (em != 0);
    endtask

    task automatic fill_zero();
      for (int a = 0; a < 2*NB; a++) mem[a] = '0;
    endtask

    task automatic fill_rand();
      for (int a = 0; a < 2*NB; a++) begin
        case ($urandom_range(0, 3))
          0:       mem[a] = DW'($urandom);
          1:       mem[a] = '0;
          default: mem[a] = DW'($urandom_range(0, 40)) - DW'(20);
        endcase
      end
    endtask

    task automatic run_scan(input longint thr, input bit pester);
      longint eb, em;
      bit     ef, got;
      int     lat, pulses, bz;
      ref_scan(thr, eb, em, ef);
      @(negedge clk);
      threshold = MW'(thr);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0; pulses = 0; got = 1'b0;
      while (!got && lat < 1000) begin
        @(negedge clk);
        lat++;
        if (mem_rd_en) pulses++;
        if (lat == 1) chk(g, "busy_rise", busy, 1);
        start = pester && lat >= 10 && lat < 13;
        if (done) got = 1'b1;
      end
      start = 1'b0;
      chk(g, "done_seen", got, 1);
      chk(g, "latency", lat, 1 + (NB-MINB)*(2*L+3));
      chk(g, "rd_pulses", pulses, 2*(NB-MINB));
      chk(g, "busy_at_done", busy, 0);
      chk(g, "peak_bin", peak_bin, eb);
      chk(g, "peak_mag", peak_mag, em);
      chk(g, "peak_found", peak_found, ef);
      last_b = eb; last_m = em; last_f = ef;
      start = pester;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk(g, "done_width", done, 0);
      bz = 0;
      repeat (20) begin
        @(negedge clk);
        bz += busy;
      end
      chk(g, "idle_after", bz, 0);
    endtask

    task automatic rand_scan(input bit pester);
      longint eb, em, thr;
      bit     ef;
      fill_rand();
      ref_scan(0, eb, em, ef);
      case ($urandom_range(0, 3))
        0:       thr = 0;
        1:       thr = em;
        2:       thr = em + 1;
        default: thr = longint'($urandom_range(0, (1 << MW) - 1));
      endcase
      run_scan(thr, pester);
    endtask

    task automatic abort_test();
      int dn, bz;
      fill_rand();
      @(negedge clk);
      threshold = '0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (19) @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk(g, "abort_busy", busy, 0);
      dn = 0; bz = 0;
      repeat (200) begin
        @(negedge clk);
        dn += done;
        bz += busy;
      end
      chk(g, "abort_no_done", dn, 0);
      chk(g, "abort_stays_idle", bz, 0);
      chk(g, "abort_keep_bin", peak_bin, last_b);
      chk(g, "abort_keep_mag", peak_mag, last_m);
      chk(g, "abort_keep_found", peak_found, last_f);
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk);
      #1 begin start = 1'b0; abort = 1'b0; end
      @(negedge clk);
      chk(g, "abort_beats_start", busy, 0);
    endtask

    task automatic reset_test();
      fill_rand();
      @(negedge clk);
      threshold = '0;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (1 + 3*(2*L+3)) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk(g, "async_reset",
             {busy, done, mem_rd_en, mem_addr, peak_bin, peak_mag, peak_found}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      last_b = 0; last_m = 0; last_f = 1'b0;
    endtask

    initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      threshold = '0;
      fill_zero();
      repeat (3) @(negedge clk);
      chk(g, "reset_state",
          {busy, done, mem_rd_en, mem_addr, peak_bin, peak_mag, peak_found}, 0);
      rst_n = 1'b1;

      fill_zero();
      mem[5] = DW'(100);
      mem[5+NB] = DW'(-50);
      run_scan(10, 1'b0);

      fill_zero();
      mem[0] = DW'(511);
      mem[3] = DW'(200);
      mem[9+NB] = DW'(-200);
      run_scan((M != 0) ? 40000 : 200, 1'b0);

      fill_zero();
      mem[7] = DW'(-512);
      mem[7+NB] = DW'(-512);
      run_scan(0, 1'b0);

      for (int k = 0; k < 4; k++) rand_scan(k == 2);
      abort_test();
      rand_scan(1'b1);
      reset_test();

      fill_zero();
      run_scan(0, 1'b0);
      run_scan(5, 1'b0);
      fin = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(cfg[0].fin && cfg[1].fin) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    if (!(cfg[0].fin && cfg[1].fin)) chk(-1, "timeout", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
